ext_chan_master: RTL and testbench

- CPU-side bridge sitting directly upstream of the RS232 channel and other ext_chan slaves.
- Converts a CPU bus read/write at a channel address into an ext_chan request/done handshake.
- Retries automatically when a slave answers with nodata, and applies a timeout.
- Returns read data or completion to the CPU, and holds the CPU stalled via halt_out until the transaction completes.

---
 rtl/ext_chan_master.sv | 216 +++++++++++++++++++++
 tb/tb_ext_chan_master.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_chan_master.sv
// CPU-side bridge that turns a CPU read/write at a channel address into an
// ext_chan request/done handshake, with nodata retry, backoff and timeout.
module ext_chan_master #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int CHAN_ADDR_LO = 0,
    parameter int CHAN_ADDR_HI = 15,
    parameter int MAX_RETRY    = 255,
    parameter int RETRY_GAP    = 2,
    parameter int TIMEOUT      = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_oe,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read_q,
    input  logic              write_q,
    output logic [DATA_W-1:0] data_out,
    output logic              read_dn,
    output logic              write_dn,
    output logic              err_out,
    output logic              halt_out,
    output logic [ADDR_W-1:0] ext_chan_no_out,
    output logic [DATA_W-1:0] ext_chan_data_out,
    output logic              ext_chan_r_q,
    output logic              ext_chan_w_q,
    input  logic [ADDR_W-1:0] ext_chan_no_in,
    input  logic [DATA_W-1:0] ext_chan_data_in,
    input  logic              ext_chan_r_dn,
    input  logic              ext_chan_w_dn,
    input  logic              ext_chan_nodata_in
);

    localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [ADDR_W-1:0] CH_LO    = ADDR_W'(CHAN_ADDR_LO);
    localparam logic [ADDR_W-1:0] CH_SPAN  = ADDR_W'(CHAN_ADDR_HI - CHAN_ADDR_LO);
    localparam logic [RW-1:0]     RET_LIM  = RW'(MAX_RETRY);
    localparam logic [RW-1:0]     RET_SAT  = '1;
    localparam logic [TW-1:0]     TMO_LIM  = TW'(TIMEOUT);
    localparam logic [TW-1:0]     TMO_SAT  = '1;
    localparam logic [3:0]        GAP_LAST = 4'(RETRY_GAP - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        BACKOFF = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic              r_op_wr, w_op_wr_nxt;
    logic [ADDR_W-1:0] r_no, w_no_nxt;
    logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
    logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
    logic              r_rq, w_rq_nxt;
    logic              r_wq, w_wq_nxt;
    logic              r_rd_dn, w_rd_dn_nxt;
    logic              r_wr_dn, w_wr_dn_nxt;
    logic              r_err, w_err_nxt;
    logic [RW-1:0]     r_retry, w_retry_nxt;
    logic [TW-1:0]     r_tmo, w_tmo_nxt;
    logic [3:0]        r_gap, w_gap_nxt;

    logic [ADDR_W:0]   w_off;
    logic              w_in_range;
    logic              w_hit;
    logic              w_dn_match;
    logic [RW-1:0]     w_retry_inc;
    logic [TW-1:0]     w_tmo_inc;

    // Range check as one subtraction so a zero lower bound needs no special case
    assign w_off       = {1'b0, addr_in} - {1'b0, CH_LO};
    assign w_in_range  = ~w_off[ADDR_W] && (w_off[ADDR_W-1:0] <= CH_SPAN);
    assign w_hit       = (read_q | write_q) & w_in_range;
    assign w_dn_match  = (r_op_wr ? ext_chan_w_dn : ext_chan_r_dn) &&
                         (ext_chan_no_in == r_no);
    assign w_retry_inc = (r_retry == RET_SAT) ? r_retry : r_retry + 1'b1;
    assign w_tmo_inc   = (r_tmo == TMO_SAT) ? r_tmo : r_tmo + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_op_wr_nxt = r_op_wr;
        w_no_nxt    = r_no;
        w_wdata_nxt = r_wdata;
        w_rdata_nxt = r_rdata;
        w_rq_nxt    = r_rq;
        w_wq_nxt    = r_wq;
        w_rd_dn_nxt = r_rd_dn;
        w_wr_dn_nxt = r_wr_dn;
        w_err_nxt   = r_err;
        w_retry_nxt = r_retry;
        w_tmo_nxt   = r_tmo;
        w_gap_nxt   = r_gap;

        case (r_state)
            IDLE: begin
                if (w_hit) begin
                    w_no_nxt    = addr_in;
                    w_wdata_nxt = data_in;
                    w_op_wr_nxt = write_q;
                    w_wq_nxt    = write_q;
                    w_rq_nxt    = ~write_q;
                    w_retry_nxt = '0;
                    w_tmo_nxt   = '0;
                    w_gap_nxt   = '0;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (w_dn_match) begin
                    w_rq_nxt    = 1'b0;
                    w_wq_nxt    = 1'b0;
                    w_rdata_nxt = r_op_wr ? '0 : ext_chan_data_in;
                    w_rd_dn_nxt = ~r_op_wr;
                    w_wr_dn_nxt = r_op_wr;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = DONE;
                end else if (ext_chan_nodata_in) begin
                    w_rq_nxt    = 1'b0;
                    w_wq_nxt    = 1'b0;
                    w_retry_nxt = w_retry_inc;
                    if ((MAX_RETRY != 0) && (w_retry_inc == RET_LIM)) begin
                        w_rdata_nxt = '0;
                        w_rd_dn_nxt = ~r_op_wr;
                        w_wr_dn_nxt = r_op_wr;
                        w_err_nxt   = 1'b1;
                        w_state_nxt = DONE;
                    end else begin
                        w_gap_nxt   = '0;
                        w_state_nxt = BACKOFF;
                    end
                end else begin
                    w_tmo_nxt = w_tmo_inc;
                    if ((TIMEOUT != 0) && (w_tmo_inc == TMO_LIM)) begin
                        w_rq_nxt    = 1'b0;
                        w_wq_nxt    = 1'b0;
                        w_rdata_nxt = '0;
                        w_rd_dn_nxt = ~r_op_wr;
                        w_wr_dn_nxt = r_op_wr;
                        w_err_nxt   = 1'b1;
                        w_state_nxt = DONE;
                    end
                end
            end
            BACKOFF: begin
                // Retry count survives the gap; only the timeout restarts
                if (r_gap == GAP_LAST) begin
                    w_rq_nxt    = ~r_op_wr;
                    w_wq_nxt    = r_op_wr;
                    w_tmo_nxt   = '0;
                    w_state_nxt = REQ;
                end else begin
                    w_gap_nxt = r_gap + 1'b1;
                end
            end
            DONE: begin
                if (!read_q && !write_q) begin
                    w_rd_dn_nxt = 1'b0;
                    w_wr_dn_nxt = 1'b0;
                    w_err_nxt   = 1'b0;
                    w_rdata_nxt = '0;
                    w_no_nxt    = '0;
                    w_wdata_nxt = '0;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_op_wr <= 1'b0;
            r_no    <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_rq    <= 1'b0;
            r_wq    <= 1'b0;
            r_rd_dn <= 1'b0;
            r_wr_dn <= 1'b0;
            r_err   <= 1'b0;
            r_retry <= '0;
            r_tmo   <= '0;
            r_gap   <= '0;
        end else if (clk_oe) begin
            r_state <= w_state_nxt;
            r_op_wr <= w_op_wr_nxt;
            r_no    <= w_no_nxt;
            r_wdata <= w_wdata_nxt;
            r_rdata <= w_rdata_nxt;
            r_rq    <= w_rq_nxt;
            r_wq    <= w_wq_nxt;
            r_rd_dn <= w_rd_dn_nxt;
            r_wr_dn <= w_wr_dn_nxt;
            r_err   <= w_err_nxt;
            r_retry <= w_retry_nxt;
            r_tmo   <= w_tmo_nxt;
            r_gap   <= w_gap_nxt;
        end
    end

    assign data_out          = r_rdata;
    assign read_dn           = r_rd_dn;
    assign write_dn          = r_wr_dn;
    assign err_out           = r_err;
    assign halt_out          = w_hit && (r_state != DONE);
    assign ext_chan_no_out   = r_no;
    assign ext_chan_data_out = r_wdata;
    assign ext_chan_r_q      = r_rq;
    assign ext_chan_w_q      = r_wq;

endmodule

// File: tb/tb_ext_chan_master.sv
// Bench for ext_chan_master: directed scenarios with literal expectations plus
// randomized CPU/slave traffic checked every cycle against a behavioural model.
module tb_ext_chan_master;

    localparam int AW   = 8;
    localparam int DW   = 8;
    localparam int LO   = 0;
    localparam int HI   = 15;
    localparam int MAXR = 3;
    localparam int GAP  = 2;
    localparam int TMO  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clk_oe = 1'b1;
    logic [AW-1:0] addr_in = '0;
    logic [DW-1:0] data_in = '0;
    logic          read_q = 1'b0;
    logic          write_q = 1'b0;
    logic [DW-1:0] data_out;
    logic          read_dn, write_dn, err_out, halt_out;
    logic [AW-1:0] ext_chan_no_out;
    logic [DW-1:0] ext_chan_data_out;
    logic          ext_chan_r_q, ext_chan_w_q;
    logic [AW-1:0] ext_chan_no_in = '0;
    logic [DW-1:0] ext_chan_data_in = '0;
    logic          ext_chan_r_dn = 1'b0;
    logic          ext_chan_w_dn = 1'b0;
    logic          ext_chan_nodata_in = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    ext_chan_master #(
        .ADDR_W(AW), .DATA_W(DW), .CHAN_ADDR_LO(LO), .CHAN_ADDR_HI(HI),
        .MAX_RETRY(MAXR), .RETRY_GAP(GAP), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .clk_oe(clk_oe),
        .addr_in(addr_in), .data_in(data_in),
        .read_q(read_q), .write_q(write_q),
        .data_out(data_out), .read_dn(read_dn), .write_dn(write_dn),
        .err_out(err_out), .halt_out(halt_out),
        .ext_chan_no_out(ext_chan_no_out), .ext_chan_data_out(ext_chan_data_out),
        .ext_chan_r_q(ext_chan_r_q), .ext_chan_w_q(ext_chan_w_q),
        .ext_chan_no_in(ext_chan_no_in), .ext_chan_data_in(ext_chan_data_in),
        .ext_chan_r_dn(ext_chan_r_dn), .ext_chan_w_dn(ext_chan_w_dn),
        .ext_chan_nodata_in(ext_chan_nodata_in)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: phase 0 idle, 1 requesting, 2 waiting out a gap, 3 finished
    int            phase = 0;
    int            tries = 0;
    int            waited = 0;
    int            gap_cnt = 0;
    logic          m_wr = 1'b0;
    logic [AW-1:0] m_no = '0;
    logic [DW-1:0] m_wd = '0;
    logic [DW-1:0] m_rd = '0;
    logic          m_err = 1'b0;

    function automatic bit tb_hit();
        return (read_q || write_q) && (int'(addr_in) >= LO) && (int'(addr_in) <= HI);
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            phase = 0; tries = 0; waited = 0; gap_cnt = 0;
            m_wr = 1'b0; m_no = '0; m_wd = '0; m_rd = '0; m_err = 1'b0;
        end else if (clk_oe) begin
            case (phase)
                0: if (tb_hit()) begin
                    m_no = addr_in; m_wd = data_in; m_wr = write_q;
                    tries = 0; waited = 0; phase = 1;
                end
                1: begin
                    if ((m_wr ? ext_chan_w_dn : ext_chan_r_dn) && ext_chan_no_in == m_no) begin
                        m_rd = m_wr ? '0 : ext_chan_data_in; m_err = 1'b0; phase = 3;
                    end else if (ext_chan_nodata_in) begin
                        tries++;
                        if (MAXR != 0 && tries == MAXR) begin
                            m_rd = '0; m_err = 1'b1; phase = 3;
                        end else begin
                            gap_cnt = 0; phase = 2;
                        end
                    end else begin
                        waited++;
                        if (TMO != 0 && waited == TMO) begin
                            m_rd = '0; m_err = 1'b1; phase = 3;
                        end
                    end
                end
                2: begin
                    gap_cnt++;
                    if (gap_cnt == GAP) begin
                        waited = 0; phase = 1;
                    end
                end
                default: if (!read_q && !write_q) begin
                    m_rd = '0; m_err = 1'b0; m_no = '0; m_wd = '0; phase = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_r_q",     ext_chan_r_q,      (phase == 1) && !m_wr);
            check("m_w_q",     ext_chan_w_q,      (phase == 1) && m_wr);
            check("m_no_out",  ext_chan_no_out,   m_no);
            check("m_cdata",   ext_chan_data_out, m_wd);
            check("m_read_dn", read_dn,           (phase == 3) && !m_wr);
            check("m_wr_dn",   write_dn,          (phase == 3) && m_wr);
            check("m_err",     err_out,           (phase == 3) && m_err);
            check("m_data",    data_out,          m_rd);
            check("m_halt",    halt_out,          tb_hit() && (phase != 3));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of randomized slave and clock-enable behaviour
    task automatic rstep();
        tick();
        clk_oe = ($urandom_range(0, 3) != 0);
        ext_chan_r_dn = 1'b0; ext_chan_w_dn = 1'b0; ext_chan_nodata_in = 1'b0;
        ext_chan_no_in = ext_chan_no_out;
        ext_chan_data_in = DW'($urandom);
        if (ext_chan_r_q || ext_chan_w_q) begin
            case ($urandom_range(0, 7))
                3: begin ext_chan_r_dn = ext_chan_w_q; ext_chan_w_dn = ext_chan_r_q; end
                4: ext_chan_nodata_in = 1'b1;
                5: begin ext_chan_r_dn = ext_chan_r_q; ext_chan_w_dn = ext_chan_w_q; end
                6: begin
                    ext_chan_r_dn = ext_chan_r_q; ext_chan_w_dn = ext_chan_w_q;
                    ext_chan_no_in = ext_chan_no_out ^ 8'h01;
                end
                7: begin
                    ext_chan_r_dn = ext_chan_r_q; ext_chan_w_dn = ext_chan_w_q;
                    ext_chan_nodata_in = 1'b1;
                end
                default: ;
            endcase
        end else if ($urandom_range(0, 9) == 0) begin
            ext_chan_r_dn = 1'b1; ext_chan_w_dn = 1'b1;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int low, reqs, highs, w;
        bit prev;

        tick(); tick();
        check("rst_r_q", ext_chan_r_q, 0);
        check("rst_w_q", ext_chan_w_q, 0);
        check("rst_no", ext_chan_no_out, 0);
        check("rst_dn", read_dn | write_dn, 0);
        check("rst_halt", halt_out, 0);
        rst = 1'b1;
        chk_en = 1'b1;

        // Write 0x41 to channel 3, slave completes after two cycles
        addr_in = 8'd3; data_in = 8'h41; write_q = 1'b1;
        #1 check("wr_halt_on", halt_out, 1);
        tick();
        check("wr_w_q", ext_chan_w_q, 1);
        check("wr_r_q", ext_chan_r_q, 0);
        check("wr_no", ext_chan_no_out, 3);
        check("wr_cdata", ext_chan_data_out, 8'h41);
        tick(); tick();
        ext_chan_w_dn = 1'b1; ext_chan_no_in = 8'd3;
        tick();
        ext_chan_w_dn = 1'b0;
        check("wr_dn", write_dn, 1);
        check("wr_err", err_out, 0);
        check("wr_halt_off", halt_out, 0);
        check("wr_w_q_drop", ext_chan_w_q, 0);
        write_q = 1'b0;
        tick();
        check("wr_dn_clr", write_dn, 0);
        check("wr_no_clr", ext_chan_no_out, 0);
        check("wr_cdata_clr", ext_chan_data_out, 0);

        // Read channel 3: two nodata replies, then data 0x5A
        read_q = 1'b1;
        tick();
        check("rd_r_q", ext_chan_r_q, 1);
        for (int k = 0; k < 2; k++) begin
            ext_chan_nodata_in = 1'b1;
            tick();
            ext_chan_nodata_in = 1'b0;
            low = 0;
            while (!ext_chan_r_q && low < 10) begin
                low++;
                tick();
            end
            check("rd_gap_len", low, GAP);
        end
        ext_chan_r_dn = 1'b1; ext_chan_no_in = 8'd3; ext_chan_data_in = 8'h5A;
        tick();
        ext_chan_r_dn = 1'b0;
        check("rd_dn", read_dn, 1);
        check("rd_data", data_out, 8'h5A);
        check("rd_err", err_out, 0);
        read_q = 1'b0;
        tick();

        // Slave always nodata: retry limit
        addr_in = 8'd9; read_q = 1'b1; ext_chan_nodata_in = 1'b1;
        reqs = 0; prev = 1'b0; w = 0;
        while (!read_dn && w < 100) begin
            tick();
            w++;
            if (ext_chan_r_q && !prev) reqs++;
            prev = ext_chan_r_q;
        end
        check("rty_reqs", reqs, MAXR);
        check("rty_dn", read_dn, 1);
        check("rty_err", err_out, 1);
        check("rty_data", data_out, 0);
        ext_chan_nodata_in = 1'b0; read_q = 1'b0;
        tick();

        // Silent slave: timeout
        addr_in = 8'd7; data_in = 8'h33; write_q = 1'b1;
        highs = 0; w = 0;
        while (!write_dn && w < 100) begin
            tick();
            w++;
            if (ext_chan_w_q) highs++;
        end
        check("tmo_len", highs, TMO);
        check("tmo_dn", write_dn, 1);
        check("tmo_err", err_out, 1);
        write_q = 1'b0;
        tick();

        // Both requests at channel 5: write wins
        addr_in = 8'd5; data_in = 8'h77; read_q = 1'b1; write_q = 1'b1;
        tick();
        check("both_w_q", ext_chan_w_q, 1);
        check("both_r_q", ext_chan_r_q, 0);
        ext_chan_w_dn = 1'b1; ext_chan_no_in = 8'd5;
        tick();
        ext_chan_w_dn = 1'b0;
        check("both_wr_dn", write_dn, 1);
        check("both_rd_dn", read_dn, 0);
        read_q = 1'b0; write_q = 1'b0;
        tick();

        // Out-of-range address is ignored
        addr_in = 8'd20; read_q = 1'b1;
        #1 check("oor_halt", halt_out, 0);
        repeat (3) tick();
        check("oor_r_q", ext_chan_r_q, 0);
        check("oor_dn", read_dn, 0);
        read_q = 1'b0;
        tick();

        // Reset during REQ while clk_oe is low
        addr_in = 8'd3; data_in = 8'h12; write_q = 1'b1;
        tick();
        check("rq_w_q", ext_chan_w_q, 1);
        clk_oe = 1'b0; rst = 1'b0;
        tick();
        check("rq_rst_w_q", ext_chan_w_q, 0);
        check("rq_rst_no", ext_chan_no_out, 0);
        check("rq_rst_cdata", ext_chan_data_out, 0);
        rst = 1'b1; write_q = 1'b0; clk_oe = 1'b1;
        tick();

        // State advances only on clk_oe edges
        clk_oe = 1'b0; addr_in = 8'd4; read_q = 1'b1;
        repeat (3) tick();
        check("oe_hold_r_q", ext_chan_r_q, 0);
        check("oe_hold_halt", halt_out, 1);
        clk_oe = 1'b1;
        tick();
        check("oe_r_q", ext_chan_r_q, 1);
        check("oe_no", ext_chan_no_out, 4);
        clk_oe = 1'b0; ext_chan_r_dn = 1'b1; ext_chan_no_in = 8'd4; ext_chan_data_in = 8'hA5;
        repeat (2) tick();
        check("oe_dn_held", read_dn, 0);
        clk_oe = 1'b1;
        tick();
        ext_chan_r_dn = 1'b0;
        check("oe_dn", read_dn, 1);
        check("oe_data", data_out, 8'hA5);
        read_q = 1'b0;
        tick();

        // Randomized traffic against the model
        for (int t = 0; t < 150; t++) begin
            int a;
            int op;
            a  = $urandom_range(0, 23);
            op = $urandom_range(0, 2);
            addr_in = AW'(a);
            data_in = DW'($urandom);
            read_q  = (op != 1);
            write_q = (op != 0);
            if (a > HI) begin
                repeat (4) rstep();
            end else begin
                w = 0;
                while (!(read_dn || write_dn) && w < 600) begin
                    rstep();
                    w++;
                end
                check("rnd_done", read_dn | write_dn, 1);
                repeat ($urandom_range(0, 2)) rstep();
            end
            read_q = 1'b0; write_q = 1'b0;
            w = 0;
            do begin
                rstep();
                w++;
            end while ((read_dn || write_dn) && w < 100);
            check("rnd_release", read_dn | write_dn, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
